// File: rtl/hex_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroller_if
//  Description : Control, message-ROM and display signals of hex_scroller.
//  Revision    : 1.0  initial release
// ============================================================================
interface hex_scroller_if #(
    parameter int NUM_DIGITS = 6,
    parameter int ADDR_W     = 5
);
    logic                    run;
    logic                    dir;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_q;
    logic [7*NUM_DIGITS-1:0] hex;
    logic [ADDR_W-1:0]       start;
    logic                    refresh_done;

    modport master (
        output run, dir, mem_q,
        input  mem_addr, hex, start, refresh_done
    );

    modport slave (
        input  run, dir, mem_q,
        output mem_addr, hex, start, refresh_done
    );
endinterface
`default_nettype wire

// File: rtl/hex_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroller
//  Description : Scrolls a NUM_DIGITS window over a ROM message onto 7-seg HEX.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16,
    parameter int ADDR_W     = 5,
    parameter int TICK_DIV   = 25000000
) (
    input  logic          Clock,
    input  logic          Reset,
    hex_scroller_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(MSG_LEN - 1);
    localparam logic [6:0]        c_BLANK = 7'b1111111;

    typedef enum logic [0:0] {S_FILL = 1'b0, S_WAIT = 1'b1} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [TW-1:0]           r_tick_cnt;
    logic [7*NUM_DIGITS-1:0] r_stage, w_stage_nxt;
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [ADDR_W-1:0]       r_start, w_start_nxt;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_done;
    logic                    w_tick, w_last, w_advance;
    logic [6:0]              w_dec;

    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        return (a == c_LAST) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] f_dec(input logic [ADDR_W-1:0] a);
        return (a == '0) ? c_LAST : a - 1'b1;
    endfunction

    function automatic logic [6:0] f_decode(input logic [7:0] ch);
        case (ch)
            8'd48:   return 7'b1000000;
            8'd49:   return 7'b1111001;
            8'd50:   return 7'b0100100;
            8'd51:   return 7'b0110000;
            8'd52:   return 7'b0011001;
            8'd53:   return 7'b0010010;
            8'd54:   return 7'b0000010;
            8'd55:   return 7'b1111000;
            8'd56:   return 7'b0000000;
            8'd57:   return 7'b0010000;
            8'd65:   return 7'b0001000;
            8'd98:   return 7'b0000011;
            8'd67:   return 7'b1000110;
            8'd100:  return 7'b0100001;
            8'd69:   return 7'b0000110;
            8'd70:   return 7'b0001110;
            8'd103:  return 7'b0010000;
            8'd104:  return 7'b0001011;
            8'd45:   return 7'b0111111;
            default: return c_BLANK;
        endcase
    endfunction

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_dec       = f_decode(bus.mem_q);
    assign w_start_nxt = bus.dir ? f_dec(r_start) : f_inc(r_start);

    // Data for fill cycle c belongs to character c-1, i.e. digit NUM_DIGITS-c.
    always_comb begin
        w_stage_nxt = r_stage;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_cnt == CW'(k + 1)) begin
                w_stage_nxt[7*(NUM_DIGITS-1-k) +: 7] = w_dec;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_FILL: begin
                if (r_cnt == CW'(NUM_DIGITS)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_tick && bus.run) begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt      <= '0;
            r_tick_cnt <= '0;
            r_stage    <= {NUM_DIGITS{c_BLANK}};
            r_hex      <= {NUM_DIGITS{c_BLANK}};
            r_start    <= '0;
            r_addr     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= w_last;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (r_state == S_FILL) begin
                r_stage <= w_stage_nxt;
                if (w_last) begin
                    r_hex <= w_stage_nxt;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // Last address is issued in cycle NUM_DIGITS-1 and then held.
                if (r_cnt < CW'(NUM_DIGITS - 1)) begin
                    r_addr <= f_inc(r_addr);
                end
            end else if (w_advance) begin
                r_start <= w_start_nxt;
                r_addr  <= w_start_nxt;
            end
        end
    end

    assign bus.mem_addr     = r_addr;
    assign bus.hex          = r_hex;
    assign bus.start        = r_start;
    assign bus.refresh_done = r_done;
endmodule
`default_nettype wire
